ht_link_list: RTL and testbench

HT_LINK_LIST -- requirements
Module: ht_link_list

---
 rtl/ht_link_list.sv | 163 ++++++++++++++++
 tb/tb_ht_link_list.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ht_link_list.sv
// Singly linked list of rho-keyed counters held in a MAX_NODES x 32 node pool.
// Optional macro HT_LINK_LIST_COUNT_SAT_EN makes the per-node count saturate instead of wrap.
module ht_link_list #(
   parameter int MAX_NODES = 64
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [9:0]  rho_i,
   input  logic        append_i,
   input  logic        search_i,
   output logic        done_o,
   output logic        append_o,
   output logic        found_o,
   output logic [31:0] node_o
);

   localparam int         IW       = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
   localparam logic [7:0] NULL_IDX = 8'hFF;
   localparam logic [7:0] CAP      = 8'(MAX_NODES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WALK   = 2'd1,
      UPDATE = 2'd2,
      DONE   = 2'd3
   } state_t;

   logic [31:0]   mem_r [MAX_NODES];
   state_t        state_r;
   logic [7:0]    head_r;
   logic [7:0]    tail_r;
   logic [7:0]    cnt_r;
   logic [IW-1:0] cur_r;
   logic [9:0]    key_r;
   logic          op_app_r;
   logic          hit_r;

   logic [31:0]   cur_node_s;
   logic [31:0]   hit_node_s;
   logic [31:0]   new_node_s;
   logic          can_add_s;
   logic          wr_en_s;
   logic [IW-1:0] wr_idx_s;
   logic [31:0]   wr_data_s;
   logic          link_en_s;

   function automatic logic [13:0] bump_count(input logic [13:0] c);
`ifdef HT_LINK_LIST_COUNT_SAT_EN
      bump_count = (c == 14'h3FFF) ? c : c + 14'd1;
`else
      bump_count = c + 14'd1;
`endif
   endfunction

   assign cur_node_s = mem_r[cur_r];
   assign hit_node_s = {cur_node_s[31:24], bump_count(cur_node_s[23:10]), cur_node_s[9:0]};
   assign new_node_s = {NULL_IDX, 14'd1, key_r};
   assign can_add_s  = (cnt_r < CAP);

   // Node-pool write controls for the UPDATE step (count bump, or new node plus tail link)
   always_comb begin
      wr_en_s   = 1'b0;
      wr_idx_s  = cur_r;
      wr_data_s = hit_node_s;
      link_en_s = 1'b0;
      if ((state_r == UPDATE) && op_app_r) begin
         if (hit_r) begin
            wr_en_s = 1'b1;
         end else if (can_add_s) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = cnt_r[IW-1:0];
            wr_data_s = new_node_s;
            link_en_s = (tail_r != NULL_IDX);
         end else begin
            wr_en_s = 1'b0;
         end
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // Node pool storage; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_idx_s] <= wr_data_s;
      end
      if (link_en_s) begin
         mem_r[tail_r[IW-1:0]][31:24] <= cnt_r;
      end
   end

   // Control FSM, list pointers and registered result outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r  <= IDLE;
         head_r   <= NULL_IDX;
         tail_r   <= NULL_IDX;
         cnt_r    <= 8'd0;
         cur_r    <= '0;
         key_r    <= 10'd0;
         op_app_r <= 1'b0;
         hit_r    <= 1'b0;
         done_o   <= 1'b0;
         append_o <= 1'b0;
         found_o  <= 1'b0;
         node_o   <= 32'd0;
      end else begin
         case (state_r)
            IDLE: begin
               done_o <= 1'b0;
               if (append_i || search_i) begin
                  op_app_r <= append_i;
                  key_r    <= rho_i;
                  hit_r    <= 1'b0;
                  cur_r    <= head_r[IW-1:0];
                  append_o <= 1'b0;
                  found_o  <= 1'b0;
                  node_o   <= 32'd0;
                  state_r  <= (head_r == NULL_IDX) ? UPDATE : WALK;
               end
            end
            WALK: begin
               if (cur_node_s[9:0] == key_r) begin
                  hit_r   <= 1'b1;
                  state_r <= UPDATE;
               end else if (cur_node_s[31:24] == NULL_IDX) begin
                  state_r <= UPDATE;
               end else begin
                  cur_r <= cur_node_s[24 +: IW];
               end
            end
            UPDATE: begin
               state_r <= DONE;
               if (op_app_r) begin
                  if (hit_r) begin
                     found_o <= 1'b1;
                     node_o  <= hit_node_s;
                  end else if (can_add_s) begin
                     append_o <= 1'b1;
                     node_o   <= new_node_s;
                     tail_r   <= cnt_r;
                     cnt_r    <= cnt_r + 8'd1;
                     if (tail_r == NULL_IDX) begin
                        head_r <= cnt_r;
                     end
                  end
               end else if (hit_r) begin
                  found_o <= 1'b1;
                  node_o  <= cur_node_s;
               end
            end
            DONE: begin
               done_o  <= 1'b1;
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ht_link_list.sv
// Self-checking bench for ht_link_list: directed and random append/search traffic
// checked against a position-indexed queue model of the list.
module tb_ht_link_list;

   logic        clk = 1'b0;
   logic        rstn;
   logic [9:0]  rho_a, rho_b;
   logic        app_a, srch_a, app_b, srch_b;
   logic        done_a, appo_a, found_a, done_b, appo_b, found_b;
   logic [31:0] node_a, node_b;

   logic        sel_b;
   logic        d_done, d_app, d_found;
   logic [31:0] d_node;

   int          vectors = 0;
   int          miscompares = 0;

   logic [9:0]  mk[$];
   logic [13:0] mc[$];
   int          mcap;

   always #5 clk = ~clk;

   ht_link_list #(.MAX_NODES(64)) dut_a (
      .clk(clk), .rstn(rstn), .rho_i(rho_a), .append_i(app_a), .search_i(srch_a),
      .done_o(done_a), .append_o(appo_a), .found_o(found_a), .node_o(node_a));

   ht_link_list #(.MAX_NODES(2)) dut_b (
      .clk(clk), .rstn(rstn), .rho_i(rho_b), .append_i(app_b), .search_i(srch_b),
      .done_o(done_b), .append_o(appo_b), .found_o(found_b), .node_o(node_b));

   assign d_done  = sel_b ? done_b  : done_a;
   assign d_app   = sel_b ? appo_b  : appo_a;
   assign d_found = sel_b ? found_b : found_a;
   assign d_node  = sel_b ? node_b  : node_a;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [13:0] next_count(input logic [13:0] c);
`ifdef HT_LINK_LIST_COUNT_SAT_EN
      return (c == 14'h3FFF) ? 14'h3FFF : c + 14'd1;
`else
      return c + 14'd1;
`endif
   endfunction

   // Nodes live at their insertion position; the successor of position i is i+1.
   function automatic void model(input bit app, input logic [9:0] rho, output int lat,
                                 output logic ea, output logic ef, output logic [31:0] en);
      int idx;
      logic [7:0] nxt;
      idx = -1;
      foreach (mk[i]) if (idx < 0 && mk[i] == rho) idx = i;
      ea = 1'b0; ef = 1'b0; en = 32'd0;
      if (idx >= 0) begin
         lat = idx + 3;
         ef  = 1'b1;
         if (app) mc[idx] = next_count(mc[idx]);
         nxt = (idx == mk.size() - 1) ? 8'hFF : 8'(idx + 1);
         en  = {nxt, mc[idx], rho};
      end else begin
         lat = mk.size() + 2;
         if (app && mk.size() < mcap) begin
            mk.push_back(rho);
            mc.push_back(14'd1);
            ea = 1'b1;
            en = {8'hFF, 14'd1, rho};
         end
      end
   endfunction

   task automatic do_op(input bit on_b, input bit app, input logic [9:0] rho);
      int elat, lat;
      logic ea, ef;
      logic [31:0] en;
      model(app, rho, elat, ea, ef, en);
      @(negedge clk);
      sel_b = on_b;
      if (on_b) begin app_b = app; srch_b = !app; rho_b = rho; end
      else      begin app_a = app; srch_a = !app; rho_a = rho; end
      @(posedge clk); #1;
      app_a = 1'b0; srch_a = 1'b0; app_b = 1'b0; srch_b = 1'b0;
      check("accept_node_clear", d_node, 32'd0);
      check("accept_flag_clear", {30'd0, d_app, d_found}, 32'd0);
      lat = 0;
      while (lat < 300 && d_done !== 1'b1) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, elat);
      check("append_o", {31'd0, d_app}, {31'd0, ea});
      check("found_o", {31'd0, d_found}, {31'd0, ef});
      check("node_o", d_node, en);
      @(posedge clk); #1;
      check("done_one_cycle", {31'd0, d_done}, 32'd0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_a"}, {done_a, appo_a, found_a, 29'd0} | node_a, 32'd0);
      check({tag, "_b"}, {done_b, appo_b, found_b, 29'd0} | node_b, 32'd0);
   endtask

   initial begin
      rstn = 1'b0; sel_b = 1'b0;
      app_a = 1'b0; srch_a = 1'b0; rho_a = 10'd0;
      app_b = 1'b0; srch_b = 1'b0; rho_b = 10'd0;
      #12;
      check_outputs_zero("reset_outputs");
      @(negedge clk); rstn = 1'b1;

      // Capacity-2 instance: third distinct append has nowhere to go
      mcap = 2;
      do_op(1'b1, 1'b1, 10'd1);
      do_op(1'b1, 1'b1, 10'd2);
      do_op(1'b1, 1'b1, 10'd3);
      do_op(1'b1, 1'b0, 10'd3);
      do_op(1'b1, 1'b0, 10'd2);

      mk.delete(); mc.delete(); mcap = 64;
      do_op(1'b0, 1'b1, 10'd123);
      do_op(1'b0, 1'b1, 10'd123);
      do_op(1'b0, 1'b1, 10'd321);
      do_op(1'b0, 1'b0, 10'd123);
      do_op(1'b0, 1'b0, 10'd789);
      do_op(1'b0, 1'b0, 10'd321);

      for (int n = 0; n < 200; n++) begin
         do_op(1'b0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 19)));
      end

      // Reset from IDLE with live outputs, then count rollover on a preloaded node
      @(negedge clk); rstn = 1'b0;
      #2;
      check_outputs_zero("reset_idle");
      @(negedge clk); rstn = 1'b1;
      mk.delete(); mc.delete();
      do_op(1'b0, 1'b1, 10'd123);
      @(negedge clk);
      dut_a.mem_r[0] = {8'hFF, 14'h3FFF, 10'd123};
      mc[0] = 14'h3FFF;
      do_op(1'b0, 1'b1, 10'd123);
      do_op(1'b0, 1'b1, 10'd321);

      // Abort a search while it is walking the list
      @(negedge clk);
      sel_b = 1'b0; srch_a = 1'b1; rho_a = 10'd789;
      @(posedge clk); #1;
      srch_a = 1'b0;
      @(posedge clk); #2;
      rstn = 1'b0;
      #1;
      check_outputs_zero("reset_mid_walk");
      @(negedge clk); rstn = 1'b1;
      mk.delete(); mc.delete();
      do_op(1'b0, 1'b0, 10'd123);
      do_op(1'b0, 1'b1, 10'd55);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
